// File: rtl/bus_rr_arbiter4.sv
// bus_rr_arbiter4: four-master round-robin bus arbiter with registered one-hot grant,
// a one-cycle turnaround gap between owners and a hold limit under contention.
module bus_rr_arbiter4 #(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] grant_id,
   output logic       bus_busy,
   output logic       preempt
);
   typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   state_t            state_q, state_d;
   logic [1:0]        owner_q, owner_d, last_q, last_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              preempt_q, preempt_d;
   logic [7:0]        req_rot;
   logic [1:0]        rr_off, rr_idx;
   logic              others;
   // Rotate so bit 0 is the master just after last_q; first set bit wins.
   assign req_rot = {req, req} >> (3'(last_q) + 3'd1);
   assign rr_off  = req_rot[0] ? 2'd0 : req_rot[1] ? 2'd1 : req_rot[2] ? 2'd2 : 2'd3;
   assign rr_idx  = last_q + 2'd1 + rr_off;
   assign others  = |(req & ~(4'b0001 << owner_q));
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      hold_d    = hold_q;
      preempt_d = 1'b0;
      if (state_q == OWN) begin
         if (!req[owner_q]) begin
            state_d = TURN;
            last_d  = owner_q;
         end else if (hold_q >= HOLD_MAX && others) begin
            state_d   = TURN;
            last_d    = owner_q;
            preempt_d = 1'b1;
         end else begin
            hold_d = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + 1'b1;
         end
      end else if (|req) begin
         state_d = OWN;
         owner_d = rr_idx;
         hold_d  = HOLD_W'(1);
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         owner_q   <= 2'd0;
         last_q    <= 2'd3;
         hold_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end
   assign grant    = (state_q == OWN) ? (4'b0001 << owner_q) : 4'b0000;
   assign grant_id = (state_q == OWN) ? owner_q : 2'd0;
   assign bus_busy = (state_q == OWN);
   assign preempt  = preempt_q;
endmodule
